reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Consumes the debounced button-reset pulse and produces the staged system resets for the PC core. A power-on reset or a rising edge on `drst` asserts `sys_rst` and `cpu_rst` together. `sys_rst` (bus, peripherals, memory controller) releases first; `cpu_rst` releases a fixed number of cycles later, so the 8088 core leaves reset only after its peripherals are stable. The block sits between the `debounce` output and every reset consumer in the design.

## Interface
- `HOLD_CYCLES`, 16: cycles `sys_rst` stays high after a trigger (≥2).
- `STAGGER_CYCLES`, 4: cycles between `sys_rst` release and `cpu_rst` release (≥1).
- `CNT_W`, 5: width of the internal cycle counter; must hold max(HOLD_CYCLES, STAGGER_CYCLES)−1.
- `clk`  in  1  system clock.
- `rst`  in  1  power-on reset, asynchronous, active-low.
- `drst`  in  1  debounced reset request from `debounce`, synchronous to `clk`, 1 or more cycles high.
- `sys_rst`  out  1  active-high reset to bus and peripherals, registered.
- `cpu_rst`  out  1  active-high reset to the CPU core, registered.
- `ready`  out  1  high only in RUN.
- `rst_count`  out  8  number of accepted `drst` triggers, saturating at 255.

## Operation
- States: HOLD, STAGGER, RUN. Counter `cnt` is CNT_W bits. `drst_q` is the registered previous `drst`. Trigger is `trig = drst & ~drst_q`, so a multi-cycle `drst` pulse counts once.
- `rst` low (asynchronous):
  - state=HOLD, cnt=0, drst_q=0, rst_count=0.
  - `sys_rst`=1, `cpu_rst`=1, `ready`=0.
- Release of `rst` starts a power-on sequence in HOLD. This sequence does not increment `rst_count`.
- HOLD:
  - If `trig`: cnt←0 and rst_count++ (sequence restarts).
  - Else if cnt==HOLD_CYCLES−1: state←STAGGER, cnt←0, `sys_rst`←0.
  - Else: cnt++.
- STAGGER:
  - If `trig`: state←HOLD, cnt←0, `sys_rst`←1, rst_count++.
  - Else if cnt==STAGGER_CYCLES−1: state←RUN, `cpu_rst`←0, `ready`←1.
  - Else: cnt++.
- RUN:
  - If `trig`: state←HOLD, cnt←0, `sys_rst`←1, `cpu_rst`←1, `ready`←0, rst_count++.
- `cpu_rst` is never low while `sys_rst` is high.
- rst_count increments with saturation: at 255 it holds at 255.
- `drst` high while `rst` is asserted is ignored. If `drst` is still high at `rst` release, drst_q=0 makes it a trigger on the first edge (restart plus count).

## Timing
- `trig` sampled at edge N: `sys_rst`/`cpu_rst` high, `ready` low, and rst_count updated after edge N.
- With no retrigger:
  - `sys_rst` is high for exactly HOLD_CYCLES edges counted from the trigger edge (trigger edge excluded).
  - `cpu_rst` falls exactly STAGGER_CYCLES edges after `sys_rst` falls.
- Power-on: `sys_rst` falls at the HOLD_CYCLES-th rising edge after `rst` deasserts. `cpu_rst` falls STAGGER_CYCLES edges later.
- All outputs are registered. There is no combinational path from `drst` to any output.

## Structure
- Shared package `pc_reset_pkg`:
  - state enum `rst_state_t` {HOLD, STAGGER, RUN}.
  - default constants `RST_HOLD_CYCLES`=16 and `RST_STAGGER_CYCLES`=4.
- Sub-module `edge_detect_rise`: one flop plus AND, producing `trig`. It is reusable for other button inputs.
- All other logic is one FSM plus counter in `reset_sequencer`.

## Test plan
All scenarios use defaults HOLD=16, STAGGER=4.
- Power-on: hold `rst`=0 for 3 cycles, then release. Check: `sys_rst`=`cpu_rst`=1 during reset; `sys_rst` falls at edge 16 after release; `cpu_rst` falls at edge 20; `ready`=1 at edge 20; rst_count=0.
- Single trigger from RUN: `drst` high for 2 cycles (debounce pulse shape). Check: both resets rise after the first edge; rst_count=1; `sys_rst` falls 16 edges later; `cpu_rst` falls 4 edges after that.
- Retrigger in HOLD: second `drst` rising edge 8 cycles after the first. Check: `sys_rst` stays high a further 16 edges from the second trigger; rst_count=2; `cpu_rst` never glitches low.
- Retrigger in STAGGER: trigger 2 cycles after `sys_rst` falls. Check: `sys_rst` re-asserts the next cycle while `cpu_rst` stays 1; full 16+4 sequence follows; count increments.
- Saturation: 260 spaced triggers, each waiting for RUN. Check: rst_count=255 and held there.
- Async reset mid-sequence: pull `rst` low during STAGGER between edges. Check: immediate `sys_rst`=1, rst_count=0, `ready`=0; full power-on sequence follows release.

Source files
------------

// File: rtl/pc_reset_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_reset_pkg
//  Description : Shared reset-sequencing types and default timing constants
//                for the PC core reset tree.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_reset_pkg;

   // Default hold time for sys_rst and the sys_rst -> cpu_rst release gap
   localparam int RST_HOLD_CYCLES    = 16;
   localparam int RST_STAGGER_CYCLES = 4;

   // Sequencer phases: both resets held, sys released / cpu held, all released
   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      STAGGER = 2'd1,
      RUN     = 2'd2
   } rst_state_t;

endpackage : pc_reset_pkg
`default_nettype wire

// File: rtl/edge_detect_rise.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detect_rise
//  Description : Rising-edge detector for a signal already synchronous to clk.
//                One flop holds the previous sample, and rise = d & ~previous.
//                The flop clears on reset, so a level that is already high
//                when reset releases appears as an edge on the first clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_detect_rise (
   input  logic clk,
   input  logic rst,    // asynchronous, active-low
   input  logic d,
   output logic rise
);

   logic r_q;

   // Keep the previous sample of d
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_q <= 1'b0;
      else      r_q <= d;
   end

   assign rise = d & ~r_q;

endmodule : edge_detect_rise
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Staged reset generator for the PC core. A power-on reset or
//                a new debounced button press asserts sys_rst and cpu_rst.
//                sys_rst releases after HOLD_CYCLES, and cpu_rst releases
//                STAGGER_CYCLES later, so the CPU leaves reset only after the
//                bus and peripherals are stable. Every output is registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
   import pc_reset_pkg::*;
#(
   parameter int HOLD_CYCLES    = RST_HOLD_CYCLES,
   parameter int STAGGER_CYCLES = RST_STAGGER_CYCLES,
   parameter int CNT_W          = 5
) (
   input  logic       clk,
   input  logic       rst,        // power-on reset, asynchronous, active-low
   input  logic       drst,       // debounced reset request
   output logic       sys_rst,
   output logic       cpu_rst,
   output logic       ready,
   output logic [7:0] rst_count
);

   localparam logic [CNT_W-1:0] C_HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

   rst_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_trig;

   // A held drst counts as one request: only its rising edge is used
   edge_detect_rise u_trig_det (
      .clk  (clk),
      .rst  (rst),
      .d    (drst),
      .rise (w_trig)
   );

   // Sequencer FSM. A trigger in any state restarts the full hold sequence
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= HOLD;
         r_cnt     <= '0;
         sys_rst   <= 1'b1;
         cpu_rst   <= 1'b1;
         ready     <= 1'b0;
         rst_count <= '0;
      end else if (w_trig) begin
         r_state   <= HOLD;
         r_cnt     <= '0;
         sys_rst   <= 1'b1;
         cpu_rst   <= 1'b1;
         ready     <= 1'b0;
         if (rst_count != 8'hFF) rst_count <= rst_count + 8'd1;
      end else begin
         case (r_state)
            HOLD: begin
               if (r_cnt == C_HOLD_LAST) begin
                  r_state <= STAGGER;
                  r_cnt   <= '0;
                  sys_rst <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            STAGGER: begin
               if (r_cnt == C_STAGGER_LAST) begin
                  r_state <= RUN;
                  cpu_rst <= 1'b0;
                  ready   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RUN: begin
               r_state <= RUN;
            end
            default: begin
               // An unused encoding re-enters the safe, fully reset state
               r_state <= HOLD;
               r_cnt   <= '0;
               sys_rst <= 1'b1;
               cpu_rst <= 1'b1;
               ready   <= 1'b0;
            end
         endcase
      end
   end

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Self-checking bench for reset_sequencer. The reference model
//                keeps the number of edges since the last sequence start.
//                The outputs follow from that age alone: sys_rst while
//                age < HOLD, cpu_rst while age < HOLD+STAGGER, ready otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

   localparam int HOLD = 16;
   localparam int STAG = 4;

   logic       clk;
   logic       rst;
   logic       drst;
   logic       sys_rst;
   logic       cpu_rst;
   logic       ready;
   logic [7:0] rst_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int   m_age  = 0;
   int   m_cnt  = 0;
   logic m_prev = 1'b0;

   reset_sequencer #(
      .HOLD_CYCLES    (HOLD),
      .STAGGER_CYCLES (STAG),
      .CNT_W          (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .drst      (drst),
      .sys_rst   (sys_rst),
      .cpu_rst   (cpu_rst),
      .ready     (ready),
      .rst_count (rst_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait expired, got timeout expected event at %0t", nm, $time);
   endtask

   task automatic compare_model();
      check("model_sys_rst",   sys_rst,   (m_age < HOLD));
      check("model_cpu_rst",   cpu_rst,   (m_age < HOLD + STAG));
      check("model_ready",     ready,     (m_age >= HOLD + STAG));
      check("model_rst_count", rst_count, m_cnt[7:0]);
   endtask

   // Advance the model at each rising edge, then compare once outputs settle
   always @(posedge clk) begin
      if (!rst) begin
         m_age  = 0;
         m_cnt  = 0;
         m_prev = 1'b0;
      end else begin
         if (drst && !m_prev) begin
            m_age = 0;
            if (m_cnt < 255) m_cnt++;
         end else if (m_age < 1000) begin
            m_age++;
         end
         m_prev = drst;
      end
      #1;
      compare_model();
   end

   // The asynchronous reset must take effect without waiting for a clock edge
   always @(negedge rst) begin
      #1;
      check("async_sys_rst", sys_rst,   1'b1);
      check("async_cpu_rst", cpu_rst,   1'b1);
      check("async_ready",   ready,     1'b0);
      check("async_count",   rst_count, 8'd0);
   end

   task automatic wait_ready(input string nm);
      int k;
      for (k = 0; k < 60 && ready !== 1'b1; k++) @(negedge clk);
      if (ready !== 1'b1) timeout_fail(nm);
   endtask

   task automatic wait_sys_low(input string nm);
      int k;
      for (k = 0; k < 60 && sys_rst !== 1'b0; k++) @(negedge clk);
      if (sys_rst !== 1'b0) timeout_fail(nm);
   endtask

   // Drive drst high at the current negedge for len cycles, then drive it low
   task automatic pulse(input int len);
      drst = 1'b1;
      repeat (len) @(negedge clk);
      drst = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      drst = 1'b0;
      #2 rst = 1'b0;

      // Power-on: hold rst low for three edges, then count edges after release
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #2;
         if (k == 15) check("po_sys_high_e15", sys_rst, 1'b1);
         if (k == 16) begin
            check("po_sys_low_e16",  sys_rst, 1'b0);
            check("po_cpu_high_e16", cpu_rst, 1'b1);
         end
         if (k == 19) check("po_cpu_high_e19", cpu_rst, 1'b1);
         if (k == 20) begin
            check("po_cpu_low_e20",   cpu_rst,   1'b0);
            check("po_ready_e20",     ready,     1'b1);
            check("po_count_e20",     rst_count, 8'd0);
         end
      end
      @(negedge clk);

      // Single two-cycle trigger from RUN
      drst = 1'b1;
      @(posedge clk);
      #2;
      check("trig1_sys",   sys_rst,   1'b1);
      check("trig1_cpu",   cpu_rst,   1'b1);
      check("trig1_count", rst_count, 8'd1);
      @(negedge clk);
      @(negedge clk);
      drst = 1'b0;
      wait_ready("trig1_ready");

      // Retrigger in HOLD: second rising edge eight cycles after the first
      @(negedge clk);
      pulse(1);
      repeat (7) @(negedge clk);
      drst = 1'b1;
      @(posedge clk);
      #2;
      check("rehold_count", rst_count, 8'd3);
      check("rehold_sys",   sys_rst,   1'b1);
      @(negedge clk);
      drst = 1'b0;
      wait_ready("rehold_ready");

      // Retrigger in STAGGER, two cycles after sys_rst falls
      @(negedge clk);
      pulse(1);
      wait_sys_low("restag_sys_low");
      @(negedge clk);
      drst = 1'b1;
      @(posedge clk);
      #2;
      check("restag_sys",   sys_rst,   1'b1);
      check("restag_cpu",   cpu_rst,   1'b1);
      check("restag_ready", ready,     1'b0);
      check("restag_count", rst_count, 8'd5);
      @(negedge clk);
      drst = 1'b0;
      wait_ready("restag_ready_wait");

      // Random request pulses of random length and spacing
      for (int i = 0; i < 40; i++) begin
         pulse($urandom_range(1, 3));
         repeat ($urandom_range(1, 28)) @(negedge clk);
      end
      wait_ready("random_ready");

      // Saturation: enough spaced triggers to pass 255
      for (int i = 0; i < 260; i++) begin
         @(negedge clk);
         pulse(2);
         wait_ready("sat_ready");
      end
      check("sat_count", rst_count, 8'd255);
      @(negedge clk);
      pulse(1);
      wait_ready("sat_hold_ready");
      check("sat_count_held", rst_count, 8'd255);

      // Asynchronous reset during STAGGER, with drst held high while in reset
      @(negedge clk);
      pulse(1);
      wait_sys_low("async_sys_low");
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_mid_ready", ready, 1'b0);
      @(negedge clk);
      drst = 1'b1;
      repeat (2) @(negedge clk);
      drst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      wait_ready("async_po_ready");
      check("async_po_count", rst_count, 8'd0);

      // Release rst while drst is already high: the first edge is a trigger
      @(negedge clk);
      drst = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #2;
      check("rel_high_count", rst_count, 8'd1);
      @(negedge clk);
      drst = 1'b0;
      wait_ready("rel_high_ready");

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_reset_sequencer
`default_nettype wire
